// File: rtl/shift_if.sv
// shift_if: operand/result handshake bundle for shift_unit.
//
// Signals:
//   in_valid / in_ready   operand handshake (master -> slave)
//   a, shamt, op          operand, shift amount, mode (00 SLL, 01 SRL, 10 SRA, 11 ROR)
//   out_valid / out_ready result handshake (slave -> master)
//   result, carry_out     shifted value and last bit shifted/rotated out
//   zero, busy            result-is-zero flag, unit-not-idle flag
//
// Modports: master drives operands and out_ready; slave is the shifter.
interface shift_if #(
   parameter int unsigned WIDTH = 16
) ();
   localparam int unsigned SW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [SW-1:0]    shamt;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             zero;
   logic             busy;

   modport master (
      output in_valid, a, shamt, op, out_ready,
      input  in_ready, out_valid, result, carry_out, zero, busy
   );

   modport slave (
      input  in_valid, a, shamt, op, out_ready,
      output in_ready, out_valid, result, carry_out, zero, busy
   );
endinterface

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle shifter (SLL, SRL, SRA, ROR) for the execute stage.
// Shifts at most STEP positions per cycle; operands and results use valid/ready.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     shift_if.slave: in_valid/in_ready/a/shamt/op in, out_valid/out_ready/
//           result/carry_out/zero/busy out
module shift_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned STEP  = 4
) (
   input logic    clk_i,
   input logic    rst_n,
   shift_if.slave bus
);
   localparam int unsigned SW = $clog2(WIDTH);
   // One extra bit so a step of STEP == WIDTH is representable.
   localparam int unsigned KW = SW + 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       op_q, op_d;
   logic [SW-1:0]    rem_q, rem_d;
   logic             carry_q, carry_d;

   // Per-step shifter
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] sll_v, srl_v, sra_v, ror_v;
   logic [WIDTH-1:0] rpre, lpre;
   logic [WIDTH-1:0] shifted;
   logic             cbit;
   logic             last_step;

   always_comb begin
      k = (32'(rem_q) < STEP) ? KW'(rem_q) : KW'(STEP);
      sll_v = data_q << k;
      srl_v = data_q >> k;
      sra_v = $signed(data_q) >>> k;
      // k == 0 gives data_q << WIDTH == 0, so the rotate degenerates cleanly.
      ror_v = (data_q >> k) | (data_q << (KW'(WIDTH) - k));
      // Last bit out: right modes lose bit k-1, left shift loses bit WIDTH-k.
      rpre = data_q >> (k - KW'(1));
      lpre = data_q << (k - KW'(1));
      shifted = data_q;
      cbit = 1'b0;
      case (op_q)
         2'b00: begin shifted = sll_v; cbit = lpre[WIDTH-1]; end
         2'b01: begin shifted = srl_v; cbit = rpre[0]; end
         2'b10: begin shifted = sra_v; cbit = rpre[0]; end
         default: begin shifted = ror_v; cbit = rpre[0]; end
      endcase
      last_step = (32'(rem_q) <= STEP);
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A zero shift still spends one cycle in StShift with a
   // null step so latency is uniformly max(1, ceil(shamt/STEP)).
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (bus.in_valid) state_d = StShift;
         StShift: if (last_step) state_d = StDone;
         StDone:  if (bus.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      data_d  = data_q;
      op_d    = op_q;
      rem_d   = rem_q;
      carry_d = carry_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               data_d  = bus.a;
               op_d    = bus.op;
               rem_d   = bus.shamt;
               carry_d = 1'b0;
            end
         end
         StShift: begin
            data_d = shifted;
            rem_d  = SW'(KW'(rem_q) - k);
            if (k != '0) carry_d = cbit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         op_q    <= '0;
         rem_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         carry_q <= carry_d;
      end
   end

   // Outputs: all from registers only
   always_comb begin
      bus.in_ready  = (state_q == StIdle);
      bus.out_valid = (state_q == StDone);
      bus.busy      = (state_q != StIdle);
      bus.result    = data_q;
      bus.carry_out = carry_q;
      bus.zero      = (data_q == '0);
   end
endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned STEP  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total = 0;

   shift_if #(.WIDTH(WIDTH)) bus ();

   shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk_i (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: shift one bit at a time, remembering the bit that leaves.
   function automatic logic [16:0] ref_op(input logic [15:0] a, input int s,
                                          input logic [1:0] op);
      logic [15:0] v = a;
      logic        c = 1'b0;
      for (int i = 0; i < s; i++) begin
         case (op)
            2'b00: begin c = v[15]; v = {v[14:0], 1'b0}; end
            2'b01: begin c = v[0];  v = {1'b0, v[15:1]}; end
            2'b10: begin c = v[0];  v = {a[15], v[15:1]}; end
            default: begin c = v[0]; v = {v[0], v[15:1]}; end
         endcase
      end
      return {c, v};
   endfunction

   function automatic int ref_lat(input int s);
      return (s == 0) ? 1 : (s + STEP - 1) / STEP;
   endfunction

   // Present one operand from IDLE and wait for out_valid; lat = -1 on timeout.
   task automatic run_op(input logic [15:0] a, input logic [3:0] s, input logic [1:0] op,
                         output int lat);
      bus.a = a; bus.shamt = s; bus.op = op; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.out_valid) lat = -1;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.a = '0; bus.shamt = '0; bus.op = '0;
      rst_n = 1'b0;
      #12;
      total++;
      if ({bus.in_ready, bus.out_valid, bus.result, bus.carry_out, bus.zero, bus.busy}
          !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
         $display("FAIL reset_values: rdy=%b ov=%b res=%h c=%b z=%b busy=%b want 1 0 0000 0 1 0",
                  bus.in_ready, bus.out_valid, bus.result, bus.carry_out, bus.zero, bus.busy);
      end else passed++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [15:0] a;
      logic [3:0]  s;
      logic [1:0]  op;
      logic [15:0] res;
      logic        c;
      logic        z;
      int          lat;
   } dcase_t;

   task automatic test_directed();
      dcase_t tbl[7];
      int lat;
      tbl[0] = '{16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, 1'b0, 4};
      tbl[1] = '{16'h8001, 4'd1,  2'b01, 16'h4000, 1'b1, 1'b0, 1};
      tbl[2] = '{16'h00F1, 4'd8,  2'b00, 16'hF100, 1'b0, 1'b0, 2};
      tbl[3] = '{16'h000F, 4'd4,  2'b11, 16'hF000, 1'b1, 1'b0, 1};
      tbl[4] = '{16'h1234, 4'd0,  2'b10, 16'h1234, 1'b0, 1'b0, 1};
      tbl[5] = '{16'h0001, 4'd15, 2'b00, 16'h8000, 1'b0, 1'b0, 4};
      tbl[6] = '{16'h8000, 4'd1,  2'b00, 16'h0000, 1'b1, 1'b1, 1};
      bus.out_ready = 1'b1;
      foreach (tbl[i]) begin
         run_op(tbl[i].a, tbl[i].s, tbl[i].op, lat);
         total++;
         if (lat !== tbl[i].lat)
            $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, tbl[i].lat);
         else passed++;
         total++;
         if ({bus.result, bus.carry_out, bus.zero} !== {tbl[i].res, tbl[i].c, tbl[i].z})
            $display("FAIL directed%0d_result: got %h c=%b z=%b want %h c=%b z=%b", i,
                     bus.result, bus.carry_out, bus.zero, tbl[i].res, tbl[i].c, tbl[i].z);
         else passed++;
         @(posedge clk); #1;
         total++;
         if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100)
            $display("FAIL directed%0d_idle: rdy/ov/busy=%b%b%b want 100", i,
                     bus.in_ready, bus.out_valid, bus.busy);
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bus.out_ready = 1'b0;
      run_op(16'hFFFF, 4'd4, 2'b01, lat);
      total++;
      if (lat !== 1) $display("FAIL bp_latency: got %0d want 1", lat);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         // Pulse a competing operand mid-stall; it must be ignored.
         if (i == 1) begin
            bus.a = 16'h0001; bus.shamt = 4'd3; bus.op = 2'b00; bus.in_valid = 1'b1;
         end else bus.in_valid = 1'b0;
         @(posedge clk); #1;
         total++;
         if ({bus.out_valid, bus.in_ready, bus.result, bus.carry_out}
             !== {1'b1, 1'b0, 16'h0FFF, 1'b1})
            $display("FAIL bp_hold%0d: ov=%b rdy=%b res=%h c=%b want 1 0 0fff 1", i,
                     bus.out_valid, bus.in_ready, bus.result, bus.carry_out);
         else passed++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100)
         $display("FAIL bp_release: rdy/ov/busy=%b%b%b want 100",
                  bus.in_ready, bus.out_valid, bus.busy);
      else passed++;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus.busy, bus.out_valid} !== 2'b00)
         $display("FAIL bp_no_queue: busy/ov=%b%b want 00", bus.busy, bus.out_valid);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int lat;
      bus.out_ready = 1'b1;
      bus.a = 16'h8000; bus.shamt = 4'd12; bus.op = 2'b10; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (bus.busy !== 1'b1) $display("FAIL midrst_busy: got %b want 1", bus.busy);
      else passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.in_ready, bus.out_valid, bus.result, bus.carry_out, bus.zero, bus.busy}
          !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0})
         $display("FAIL midrst_async: rdy=%b ov=%b res=%h c=%b z=%b busy=%b want 1 0 0000 0 1 0",
                  bus.in_ready, bus.out_valid, bus.result, bus.carry_out, bus.zero, bus.busy);
      else passed++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(16'h0001, 4'd1, 2'b11, lat);
      total++;
      if ({bus.result, bus.carry_out} !== {16'h8000, 1'b1} || lat !== 1)
         $display("FAIL midrst_after: res=%h c=%b lat=%0d want 8000 1 1",
                  bus.result, bus.carry_out, lat);
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int          cyc = 0;
      int          acc_edge = 0;
      int          exp_lat = 0;
      logic [16:0] exp_v = '0;
      logic        pending = 1'b0;
      logic        prev_ov = 1'b0;
      int          nops = 0;
      repeat (1500) begin
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.a         = 16'($urandom);
         bus.shamt     = 4'($urandom);
         bus.op        = 2'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (bus.in_valid && bus.in_ready) begin
            exp_v    = ref_op(bus.a, int'(bus.shamt), bus.op);
            exp_lat  = ref_lat(int'(bus.shamt));
            acc_edge = cyc + 1;
            pending  = 1'b1;
         end
         @(posedge clk);
         cyc++;
         #1;
         if (bus.out_valid && !prev_ov) begin
            nops++;
            total++;
            if (!pending || (cyc - acc_edge) != exp_lat)
               $display("FAIL rand_latency: got %0d want %0d (pending=%b)",
                        cyc - acc_edge, exp_lat, pending);
            else passed++;
            pending = 1'b0;
         end
         if (bus.out_valid) begin
            total++;
            if ({bus.carry_out, bus.result, bus.zero} !== {exp_v, exp_v[15:0] == 16'h0})
               $display("FAIL rand_result: got %h c=%b z=%b want %h c=%b z=%b",
                        bus.result, bus.carry_out, bus.zero, exp_v[15:0], exp_v[16],
                        exp_v[15:0] == 16'h0);
            else passed++;
         end
         prev_ov = bus.out_valid;
      end
      total++;
      if (nops < 50) $display("FAIL rand_activity: got %0d ops want >= 50", nops);
      else passed++;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
